// File: rtl/porta_condicionador.sv
// -----------------------------------------------------------------------------
// porta_condicionador
//
// Input-conditioning stage for the rolling-door controller. Each of the five
// raw door switches (close/open commands, bottom/middle/top position sensors)
// is optionally double-flopped into the clk_2 domain and then debounced. The
// debounced position code is checked for one-hot validity, and a sticky
// position fault is raised when it stays invalid for too long. One-cycle
// open/close pulses are derived from the debounced command levels.
//
// Build option:
//   PORTA_COND_SYNC_EN  defined     -> 2-flop synchronizer in front of each
//                                      debouncer (latency DEB_CYCLES+2 edges)
//                       not defined -> raw inputs feed the debouncers directly
//                                      (latency DEB_CYCLES edges)
//
// Parameters:
//   DEB_CYCLES    consecutive differing cycles before a debounced output flips
//   FAULT_CYCLES  consecutive invalid-position cycles before pos_fault sets
//
// Ports:
//   clk_2         in   clock, all state on rising edge
//   reset_n       in   asynchronous active-low reset
//   fechar_raw    in   raw close command
//   abrir_raw     in   raw open command
//   em_baixo_raw  in   raw bottom sensor
//   no_meio_raw   in   raw middle sensor
//   em_cima_raw   in   raw top sensor
//   fault_clr     in   clear request for pos_fault (honoured only when valid)
//   fechar, abrir out  debounced commands
//   em_baixo, no_meio, em_cima out  debounced positions
//   abrir_pulse, fechar_pulse  out  one-cycle pulses on debounced rise
//   pos_valid     out  debounced position is exactly one-hot
//   pos_fault     out  sticky position fault
// -----------------------------------------------------------------------------
module porta_condicionador #(
  parameter int DEB_CYCLES   = 3,
  parameter int FAULT_CYCLES = 4
) (
  input  logic clk_2,
  input  logic reset_n,
  input  logic fechar_raw,
  input  logic abrir_raw,
  input  logic em_baixo_raw,
  input  logic no_meio_raw,
  input  logic em_cima_raw,
  input  logic fault_clr,
  output logic fechar,
  output logic abrir,
  output logic em_baixo,
  output logic no_meio,
  output logic em_cima,
  output logic abrir_pulse,
  output logic fechar_pulse,
  output logic pos_valid,
  output logic pos_fault
);

  localparam int CW = (DEB_CYCLES   > 0) ? $clog2(DEB_CYCLES + 1)   : 1;
  localparam int FW = (FAULT_CYCLES > 0) ? $clog2(FAULT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
  localparam logic [FW-1:0] FAULT_MAX = FW'(FAULT_CYCLES);
  localparam logic [FW-1:0] FAULT_PRE = FW'(FAULT_CYCLES - 1);

  // Channel order: 0 fechar, 1 abrir, 2 em_baixo, 3 no_meio, 4 em_cima
  logic [4:0] raw_vec;
  logic [4:0] deb_in;
  logic [4:0] deb_q;

  assign raw_vec = {em_cima_raw, no_meio_raw, em_baixo_raw, abrir_raw, fechar_raw};

`ifdef PORTA_COND_SYNC_EN
  logic [4:0] sync1_q;
  logic [4:0] sync2_q;

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_vec;
      sync2_q <= sync1_q;
    end
  end

  assign deb_in = sync2_q;
`else
  assign deb_in = raw_vec;
`endif

  // Debouncers: the counter tracks how many consecutive edges the input has
  // disagreed with the output; the flip happens on the DEB_CYCLES-th one.
  for (genvar ch = 0; ch < 5; ch++) begin : g_deb
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q     <= '0;
        deb_q[ch] <= 1'b0;
      end else if (deb_in[ch] != deb_q[ch]) begin
        if (cnt_q == DEB_LAST) begin
          cnt_q     <= '0;
          deb_q[ch] <= deb_in[ch];
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign fechar   = deb_q[0];
  assign abrir    = deb_q[1];
  assign em_baixo = deb_q[2];
  assign no_meio  = deb_q[3];
  assign em_cima  = deb_q[4];

  // Exactly one of the three position bits set
  assign pos_valid = ( em_baixo & ~no_meio & ~em_cima) |
                     (~em_baixo &  no_meio & ~em_cima) |
                     (~em_baixo & ~no_meio &  em_cima);

  // Fault counter saturates so it can never wrap back below the threshold
  logic [FW-1:0] fault_cnt_q;

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      fault_cnt_q <= '0;
      pos_fault   <= 1'b0;
    end else begin
      if (pos_valid) begin
        fault_cnt_q <= '0;
      end else if (fault_cnt_q != FAULT_MAX) begin
        fault_cnt_q <= fault_cnt_q + 1'b1;
      end

      // Set wins over clear; clear is only honoured on a valid position
      if (!pos_valid && (fault_cnt_q == FAULT_PRE)) begin
        pos_fault <= 1'b1;
      end else if (fault_clr && pos_valid) begin
        pos_fault <= 1'b0;
      end
    end
  end

  // Pulse history
  logic abrir_prev_q;
  logic fechar_prev_q;

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      abrir_prev_q  <= 1'b0;
      fechar_prev_q <= 1'b0;
    end else begin
      abrir_prev_q  <= abrir;
      fechar_prev_q <= fechar;
    end
  end

  // A rise while the opposite command is active yields no pulse
  assign abrir_pulse  = abrir  & ~abrir_prev_q  & ~fechar;
  assign fechar_pulse = fechar & ~fechar_prev_q & ~abrir;

endmodule

// File: tb/tb_porta_condicionador.sv
// -----------------------------------------------------------------------------
// tb_porta_condicionador
//
// Directed bench for porta_condicionador with default parameters. Inputs are
// driven 1 time unit after a rising edge so the next edge is "edge 1" of a
// new level; outputs are sampled at the same point, away from the edge.
// LAT follows the PORTA_COND_SYNC_EN build option.
// -----------------------------------------------------------------------------
module tb_porta_condicionador;

  localparam int DEB_CYCLES   = 3;
  localparam int FAULT_CYCLES = 4;
`ifdef PORTA_COND_SYNC_EN
  localparam int LAT = DEB_CYCLES + 2;
`else
  localparam int LAT = DEB_CYCLES;
`endif

  logic clk_2 = 1'b0;
  logic reset_n;
  logic fechar_raw, abrir_raw, em_baixo_raw, no_meio_raw, em_cima_raw;
  logic fault_clr;
  logic fechar, abrir, em_baixo, no_meio, em_cima;
  logic abrir_pulse, fechar_pulse, pos_valid, pos_fault;

  int n_checks = 0;
  int n_fail   = 0;
  int abrir_pulse_cnt  = 0;
  int fechar_pulse_cnt = 0;
  int em_baixo_seen    = 0;

  // Clock
  always #5 clk_2 = ~clk_2;

  porta_condicionador #(
    .DEB_CYCLES   (DEB_CYCLES),
    .FAULT_CYCLES (FAULT_CYCLES)
  ) dut (
    .clk_2        (clk_2),
    .reset_n      (reset_n),
    .fechar_raw   (fechar_raw),
    .abrir_raw    (abrir_raw),
    .em_baixo_raw (em_baixo_raw),
    .no_meio_raw  (no_meio_raw),
    .em_cima_raw  (em_cima_raw),
    .fault_clr    (fault_clr),
    .fechar       (fechar),
    .abrir        (abrir),
    .em_baixo     (em_baixo),
    .no_meio      (no_meio),
    .em_cima      (em_cima),
    .abrir_pulse  (abrir_pulse),
    .fechar_pulse (fechar_pulse),
    .pos_valid    (pos_valid),
    .pos_fault    (pos_fault)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advance n edges; tally pulses and em_baixo highs seen after each edge
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_2);
      #1;
      if (abrir_pulse)  abrir_pulse_cnt++;
      if (fechar_pulse) fechar_pulse_cnt++;
      if (em_baixo)     em_baixo_seen++;
    end
  endtask

  task automatic set_raw(input logic [4:0] v);
    // {em_cima, no_meio, em_baixo, abrir, fechar}
    {em_cima_raw, no_meio_raw, em_baixo_raw, abrir_raw, fechar_raw} = v;
  endtask

  initial begin
    // ---------------- reset with all raw inputs high ----------------
    reset_n   = 1'b0;
    fault_clr = 1'b0;
    set_raw(5'b11111);
    tick(3);
    check("rst_levels", {27'b0, em_cima, no_meio, em_baixo, abrir, fechar}, 32'h0);
    check("rst_pulses", {30'b0, abrir_pulse, fechar_pulse}, 32'h0);
    check("rst_pos_valid", {31'b0, pos_valid}, 32'h0);
    check("rst_pos_fault", {31'b0, pos_fault}, 32'h0);

    reset_n = 1'b1;
    abrir_pulse_cnt = 0; fechar_pulse_cnt = 0;
    tick(LAT - 1);
    check("rel_before_lat", {27'b0, em_cima, no_meio, em_baixo, abrir, fechar}, 32'h0);
    tick(1);
    check("rel_at_lat", {27'b0, em_cima, no_meio, em_baixo, abrir, fechar}, 32'h1f);
    check("rel_both_rise_no_pulse", {30'b0, abrir_pulse, fechar_pulse}, 32'h0);
    check("rel_three_hot_invalid", {31'b0, pos_valid}, 32'h0);
    tick(FAULT_CYCLES);
    check("rel_fault_after_invalid", {31'b0, pos_fault}, 32'h1);
    check("rel_pulse_count", abrir_pulse_cnt + fechar_pulse_cnt, 32'd0);

    // ---------------- glitch filter ----------------
    set_raw(5'b00000);
    tick(LAT + 2);
    check("all_low", {27'b0, em_cima, no_meio, em_baixo, abrir, fechar}, 32'h0);
    em_baixo_seen = 0;
    em_baixo_raw = 1'b1;
    tick(DEB_CYCLES - 1);
    em_baixo_raw = 1'b0;
    tick(LAT + 3);
    check("glitch_filtered", em_baixo_seen, 32'd0);

    em_baixo_raw = 1'b1;
    tick(LAT - 1);
    check("baixo_before_lat", {31'b0, em_baixo}, 32'h0);
    tick(1);
    check("baixo_at_lat", {31'b0, em_baixo}, 32'h1);
    check("baixo_valid", {31'b0, pos_valid}, 32'h1);
    check("fault_sticky", {31'b0, pos_fault}, 32'h1);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    check("fault_cleared_valid", {31'b0, pos_fault}, 32'h0);

    // ---------------- open pulse ----------------
    abrir_pulse_cnt = 0;
    abrir_raw = 1'b1;
    tick(LAT);
    check("abrir_rise", {31'b0, abrir}, 32'h1);
    check("abrir_pulse_hi", {31'b0, abrir_pulse}, 32'h1);
    tick(1);
    check("abrir_pulse_lo", {30'b0, abrir, abrir_pulse}, 32'h2);
    tick(3);
    check("abrir_pulse_once", abrir_pulse_cnt, 32'd1);
    abrir_raw = 1'b0;
    tick(LAT + 2);
    check("abrir_fall", {31'b0, abrir}, 32'h0);

    // ---------------- close held, then open: no open pulse ----------------
    fechar_pulse_cnt = 0;
    fechar_raw = 1'b1;
    tick(LAT + 2);
    check("fechar_level", {31'b0, fechar}, 32'h1);
    check("fechar_pulse_once", fechar_pulse_cnt, 32'd1);
    abrir_pulse_cnt = 0;
    abrir_raw = 1'b1;
    tick(LAT + 2);
    check("abrir_level_blocked", {31'b0, abrir}, 32'h1);
    check("abrir_pulse_blocked", abrir_pulse_cnt, 32'd0);
    set_raw(5'b00100);
    tick(LAT + 2);
    check("cmds_low", {30'b0, abrir, fechar}, 32'h0);
    check("fault_stays_clear", {31'b0, pos_fault}, 32'h0);

    // ---------------- position fault ----------------
    set_raw(5'b11000);   // top + middle, bottom off
    tick(LAT);
    check("two_hot_levels", {29'b0, em_cima, no_meio, em_baixo}, 32'h6);
    check("two_hot_invalid", {31'b0, pos_valid}, 32'h0);
    tick(FAULT_CYCLES - 1);
    check("fault_before_set", {31'b0, pos_fault}, 32'h0);
    tick(1);
    check("fault_set", {31'b0, pos_fault}, 32'h1);
    fault_clr = 1'b1;
    tick(2);
    fault_clr = 1'b0;
    check("clr_ignored_invalid", {31'b0, pos_fault}, 32'h1);
    em_cima_raw = 1'b0;
    tick(LAT);
    check("middle_valid", {31'b0, pos_valid}, 32'h1);
    check("fault_held_until_clr", {31'b0, pos_fault}, 32'h1);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    check("fault_clr_valid", {31'b0, pos_fault}, 32'h0);

    // ---------------- reset mid-debounce ----------------
    abrir_raw = 1'b1;
    tick(2);
    @(negedge clk_2);
    reset_n = 1'b0;
    #1;
    check("midrst_async", {28'b0, abrir, em_cima, no_meio, em_baixo}, 32'h0);
    tick(1);           // edge 3 passes while in reset
    reset_n = 1'b1;
    abrir_pulse_cnt = 0;
    tick(LAT - 1);
    check("midrst_abrir_low", {31'b0, abrir}, 32'h0);
    tick(1);
    check("midrst_abrir_rise", {31'b0, abrir}, 32'h1);
    check("midrst_meio_rise", {31'b0, no_meio}, 32'h1);
    check("midrst_pulse", abrir_pulse_cnt, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop if the directed sequence ever stalls
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
